// File: rtl/agex_stage_reg_if.sv
// Handshake and payload bundle for the AGEX stage register.
// The master side feeds beats in and drains them; the slave side is the register.
interface agex_stage_reg_if #(
  parameter int WORD_WIDTH = 16,
  parameter int CS_WIDTH   = 20,
  parameter int NZP_WIDTH  = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WORD_WIDTH-1:0] in_npc;
  logic [CS_WIDTH-1:0]   in_cs;
  logic [WORD_WIDTH-1:0] in_ir;
  logic [WORD_WIDTH-1:0] in_sr1;
  logic [WORD_WIDTH-1:0] in_sr2;
  logic [NZP_WIDTH-1:0]  in_cc;
  logic [NZP_WIDTH-1:0]  in_drid;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_WIDTH-1:0] out_npc;
  logic [CS_WIDTH-1:0]   out_cs;
  logic [WORD_WIDTH-1:0] out_ir;
  logic [WORD_WIDTH-1:0] out_sr1;
  logic [WORD_WIDTH-1:0] out_sr2;
  logic [NZP_WIDTH-1:0]  out_cc;
  logic [NZP_WIDTH-1:0]  out_drid;
  logic [1:0]            occupancy;

  modport master (
    output in_valid, in_npc, in_cs, in_ir, in_sr1, in_sr2, in_cc, in_drid, flush, out_ready,
    input  in_ready, out_valid, out_npc, out_cs, out_ir, out_sr1, out_sr2, out_cc, out_drid,
           occupancy
  );

  modport slave (
    input  in_valid, in_npc, in_cs, in_ir, in_sr1, in_sr2, in_cc, in_drid, flush, out_ready,
    output in_ready, out_valid, out_npc, out_cs, out_ir, out_sr1, out_sr2, out_cc, out_drid,
           occupancy
  );
endinterface

// File: rtl/agex_stage_reg.sv
// AGEX pipeline stage register: atomic payload beat, valid/ready handshake,
// synchronous flush and an optional skid entry that keeps in_ready registered.
//
// state | meaning
// EMPTY | no beat held (M-, S-)
// ONE   | main entry holds a beat (M+, S-)
// FULL  | main and skid entries both hold beats (M+, S+), SKID=1 only
module agex_stage_reg #(
  parameter int WORD_WIDTH = 16,
  parameter int CS_WIDTH   = 20,
  parameter int NZP_WIDTH  = 3,
  parameter bit SKID       = 1'b1
) (
  input logic           clk,
  input logic           reset,
  agex_stage_reg_if.slave bus
);
  localparam int PW = 4*WORD_WIDTH + CS_WIDTH + 2*NZP_WIDTH;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   m_data, s_data, in_data;
  logic            in_ready, in_fire, out_fire;
  logic            load_m, load_s, m_from_s;
  logic [1:0]      occupancy;

  assign in_data = {bus.in_npc, bus.in_cs, bus.in_ir, bus.in_sr1, bus.in_sr2,
                    bus.in_cc, bus.in_drid};

  // With the skid entry, in_ready depends only on registered state.
  assign in_ready = SKID ? (state != FULL) : ((state == EMPTY) | bus.out_ready);
  assign in_fire  = bus.in_valid & in_ready;
  assign out_fire = (state != EMPTY) & bus.out_ready;

  always_comb begin
    state_nxt = state;
    load_m    = 1'b0;
    load_s    = 1'b0;
    m_from_s  = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          load_m    = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (out_fire && in_fire) begin
          load_m = 1'b1;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end else if (in_fire && SKID) begin
          load_s    = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (out_fire) begin
          m_from_s  = 1'b1;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush discards anything accepted this cycle; payload registers just hold.
    if (bus.flush) begin
      state_nxt = EMPTY;
      load_m    = 1'b0;
      load_s    = 1'b0;
      m_from_s  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      m_data    <= '0;
      s_data    <= '0;
      occupancy <= 2'd0;
    end else begin
      state <= state_nxt;
      if (load_m)        m_data <= in_data;
      else if (m_from_s) m_data <= s_data;
      if (load_s)        s_data <= in_data;
      case (state_nxt)
        EMPTY:   occupancy <= 2'd0;
        ONE:     occupancy <= 2'd1;
        default: occupancy <= 2'd2;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state != EMPTY);
  assign bus.occupancy = occupancy;
  assign {bus.out_npc, bus.out_cs, bus.out_ir, bus.out_sr1, bus.out_sr2,
          bus.out_cc, bus.out_drid} = m_data;
endmodule

// File: tb/tb_agex_stage_reg.sv
// Directed bench for agex_stage_reg: skid, no-skid and wide instances
// checked against hand-computed expectations.
module tb_agex_stage_reg;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  agex_stage_reg_if b1 ();
  agex_stage_reg_if b0 ();
  agex_stage_reg_if #(.WORD_WIDTH(32), .CS_WIDTH(24)) bw ();

  agex_stage_reg #(.SKID(1'b1)) d1 (.clk(clk), .reset(reset), .bus(b1));
  agex_stage_reg #(.SKID(1'b0)) d0 (.clk(clk), .reset(reset), .bus(b0));
  agex_stage_reg #(.WORD_WIDTH(32), .CS_WIDTH(24)) dw (.clk(clk), .reset(reset), .bus(bw));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    b1.in_valid = 0; b1.in_npc = '0; b1.in_cs = '0; b1.in_ir = '0; b1.in_sr1 = '0;
    b1.in_sr2 = '0; b1.in_cc = '0; b1.in_drid = '0; b1.flush = 0; b1.out_ready = 0;
    b0.in_valid = 0; b0.in_npc = '0; b0.in_cs = '0; b0.in_ir = '0; b0.in_sr1 = '0;
    b0.in_sr2 = '0; b0.in_cc = '0; b0.in_drid = '0; b0.flush = 0; b0.out_ready = 0;
    bw.in_valid = 0; bw.in_npc = '0; bw.in_cs = '0; bw.in_ir = '0; bw.in_sr1 = '0;
    bw.in_sr2 = '0; bw.in_cc = '0; bw.in_drid = '0; bw.flush = 0; bw.out_ready = 0;
  endtask

  task automatic test_reset();
    idle_all();
    reset = 1;
    step(); step();
    reset = 0;
    checks++; if (b1.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", b1.out_valid); end
    checks++; if (b1.occupancy !== 2'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", b1.occupancy); end
    checks++; if (b1.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", b1.in_ready); end
    checks++; if (b1.out_npc !== 16'h0 || b1.out_cs !== 20'h0) begin failures++; $display("FAIL reset_payload npc=%h cs=%h exp=0", b1.out_npc, b1.out_cs); end
    checks++; if (b0.in_ready !== 1'b1 || b0.out_valid !== 1'b0) begin failures++; $display("FAIL reset_skid0 in_ready=%b out_valid=%b exp=1/0", b0.in_ready, b0.out_valid); end
  endtask

  task automatic test_stream();
    logic [15:0] npc;
    b1.out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      npc = 16'h3000 + 16'(2*i);
      b1.in_valid = 1; b1.in_npc = npc; b1.in_ir = ~npc; b1.in_cc = 3'(i);
      checks++; if (b1.in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready beat=%0d got=%b exp=1", i, b1.in_ready); end
      step();
      checks++;
      if (b1.out_valid !== 1'b1 || b1.out_npc !== npc || b1.out_ir !== ~npc || b1.out_cc !== 3'(i)) begin
        failures++; $display("FAIL stream_beat beat=%0d got v=%b npc=%h ir=%h cc=%0d exp npc=%h", i, b1.out_valid, b1.out_npc, b1.out_ir, b1.out_cc, npc);
      end
      checks++; if (b1.occupancy !== 2'd1) begin failures++; $display("FAIL stream_occupancy beat=%0d got=%0d exp=1", i, b1.occupancy); end
    end
    b1.in_valid = 0;
    step();
    checks++; if (b1.out_valid !== 1'b0 || b1.occupancy !== 2'd0) begin failures++; $display("FAIL stream_drain v=%b occ=%0d exp=0/0", b1.out_valid, b1.occupancy); end
    checks++; if (b1.out_npc !== 16'h300E) begin failures++; $display("FAIL stream_hold npc=%h exp=300e", b1.out_npc); end
  endtask

  task automatic test_stall();
    b1.out_ready = 0;
    b1.in_valid = 1; b1.in_npc = 16'hA000;
    step();
    checks++; if (b1.occupancy !== 2'd1 || b1.in_ready !== 1'b1 || b1.out_npc !== 16'hA000) begin failures++; $display("FAIL stall_a occ=%0d rdy=%b npc=%h exp 1/1/a000", b1.occupancy, b1.in_ready, b1.out_npc); end
    b1.in_npc = 16'hB000;
    step();
    checks++; if (b1.occupancy !== 2'd2 || b1.in_ready !== 1'b0 || b1.out_npc !== 16'hA000) begin failures++; $display("FAIL stall_b occ=%0d rdy=%b npc=%h exp 2/0/a000", b1.occupancy, b1.in_ready, b1.out_npc); end
    b1.in_npc = 16'hC000;
    step();
    checks++; if (b1.occupancy !== 2'd2 || b1.in_ready !== 1'b0 || b1.out_npc !== 16'hA000) begin failures++; $display("FAIL stall_c occ=%0d rdy=%b npc=%h exp 2/0/a000", b1.occupancy, b1.in_ready, b1.out_npc); end
    b1.out_ready = 1;
    step();
    checks++; if (b1.out_valid !== 1'b1 || b1.out_npc !== 16'hB000 || b1.in_ready !== 1'b1 || b1.occupancy !== 2'd1) begin failures++; $display("FAIL release_b v=%b npc=%h rdy=%b occ=%0d exp 1/b000/1/1", b1.out_valid, b1.out_npc, b1.in_ready, b1.occupancy); end
    step();
    checks++; if (b1.out_valid !== 1'b1 || b1.out_npc !== 16'hC000) begin failures++; $display("FAIL release_c v=%b npc=%h exp 1/c000", b1.out_valid, b1.out_npc); end
    b1.in_valid = 0;
    step();
    checks++; if (b1.out_valid !== 1'b0 || b1.occupancy !== 2'd0) begin failures++; $display("FAIL release_drain v=%b occ=%0d exp 0/0", b1.out_valid, b1.occupancy); end
  endtask

  task automatic test_flush();
    b1.out_ready = 0;
    b1.in_valid = 1; b1.in_npc = 16'h1111;
    step();
    b1.in_npc = 16'h2222;
    step();
    b1.in_npc = 16'h3333; b1.flush = 1;
    step();
    b1.flush = 0; b1.in_valid = 0;
    checks++; if (b1.out_valid !== 1'b0 || b1.occupancy !== 2'd0 || b1.in_ready !== 1'b1) begin failures++; $display("FAIL flush_full v=%b occ=%0d rdy=%b exp 0/0/1", b1.out_valid, b1.occupancy, b1.in_ready); end
    b1.out_ready = 1;
    step();
    checks++; if (b1.out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_ghost v=%b npc=%h exp v=0", b1.out_valid, b1.out_npc); end
    // beat accepted in the flush cycle from ONE must also be dropped
    b1.out_ready = 0; b1.in_valid = 1; b1.in_npc = 16'h4444;
    step();
    b1.in_npc = 16'h5555; b1.flush = 1;
    step();
    b1.flush = 0; b1.in_valid = 0;
    checks++; if (b1.out_valid !== 1'b0 || b1.occupancy !== 2'd0) begin failures++; $display("FAIL flush_one v=%b occ=%0d exp 0/0", b1.out_valid, b1.occupancy); end
  endtask

  task automatic test_skid0();
    logic [15:0] beats [3] = '{16'h0100, 16'h0200, 16'h0300};
    for (int i = 0; i < 5; i++) begin
      b0.out_ready = (i % 2 == 0);
      b0.in_valid = 1; b0.in_npc = beats[(i+1)/2];
      #1;
      checks++; if (b0.in_ready !== b0.out_ready) begin failures++; $display("FAIL skid0_ready cyc=%0d got=%b exp=%b", i, b0.in_ready, b0.out_ready); end
      step();
      checks++; if (b0.out_valid !== 1'b1 || b0.out_npc !== beats[i/2] || b0.occupancy !== 2'd1) begin failures++; $display("FAIL skid0_beat cyc=%0d v=%b npc=%h occ=%0d exp npc=%h occ=1", i, b0.out_valid, b0.out_npc, b0.occupancy, beats[i/2]); end
    end
    b0.in_valid = 0; b0.out_ready = 1;
    step();
    checks++; if (b0.out_valid !== 1'b0 || b0.occupancy !== 2'd0) begin failures++; $display("FAIL skid0_drain v=%b occ=%0d exp 0/0", b0.out_valid, b0.occupancy); end
  endtask

  task automatic test_reset_full();
    b1.out_ready = 0; b1.in_valid = 1;
    b1.in_npc = 16'hBEEF; b1.in_cs = 20'hFFFFF; b1.in_ir = 16'h1234; b1.in_sr1 = 16'h5678;
    b1.in_sr2 = 16'h9ABC; b1.in_cc = 3'b111; b1.in_drid = 3'b101;
    step(); step();
    checks++; if (b1.occupancy !== 2'd2 || b1.out_cs !== 20'hFFFFF) begin failures++; $display("FAIL prefill occ=%0d cs=%h exp 2/fffff", b1.occupancy, b1.out_cs); end
    reset = 1; b1.flush = 1;
    step();
    reset = 0; b1.flush = 0; b1.in_valid = 0;
    checks++; if (b1.out_valid !== 1'b0 || b1.in_ready !== 1'b1 || b1.occupancy !== 2'd0) begin failures++; $display("FAIL midreset_ctl v=%b rdy=%b occ=%0d exp 0/1/0", b1.out_valid, b1.in_ready, b1.occupancy); end
    checks++;
    if (b1.out_cs !== 20'h0 || b1.out_npc !== 16'h0 || b1.out_ir !== 16'h0 || b1.out_sr1 !== 16'h0 ||
        b1.out_sr2 !== 16'h0 || b1.out_cc !== 3'h0 || b1.out_drid !== 3'h0) begin
      failures++; $display("FAIL midreset_payload cs=%h npc=%h ir=%h sr1=%h sr2=%h cc=%h drid=%h exp all 0", b1.out_cs, b1.out_npc, b1.out_ir, b1.out_sr1, b1.out_sr2, b1.out_cc, b1.out_drid);
    end
    // skid entry must also have been emptied: releasing shows nothing stale
    b1.out_ready = 1;
    step();
    checks++; if (b1.out_valid !== 1'b0) begin failures++; $display("FAIL midreset_skid v=%b exp 0", b1.out_valid); end
  endtask

  task automatic test_wide();
    bw.out_ready = 1; bw.in_valid = 1;
    bw.in_cs = 24'hFFFFFF; bw.in_sr1 = 32'hFFFFFFFF; bw.in_npc = 32'hFFFFFFFF;
    bw.in_ir = 32'hFFFFFFFF; bw.in_sr2 = 32'hFFFFFFFF; bw.in_cc = 3'b111; bw.in_drid = 3'b111;
    step();
    bw.in_valid = 0;
    checks++; if (bw.out_valid !== 1'b1 || bw.out_cs !== 24'hFFFFFF) begin failures++; $display("FAIL wide_cs v=%b cs=%h exp 1/ffffff", bw.out_valid, bw.out_cs); end
    checks++; if (bw.out_sr1 !== 32'hFFFFFFFF || bw.out_npc !== 32'hFFFFFFFF || bw.out_sr2 !== 32'hFFFFFFFF) begin failures++; $display("FAIL wide_words sr1=%h npc=%h sr2=%h exp ffffffff", bw.out_sr1, bw.out_npc, bw.out_sr2); end
  endtask

  initial begin
    reset = 1;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_skid0();
    test_reset_full();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/agex_stage_reg.md
# agex_stage_reg

Parametrised pipeline stage register for the AGEX boundary of the LC-3b pipeline. It carries the full stage payload: NPC, control-store word, IR, SR1/SR2 values, CC and destination register ID. The per-field load strobes are replaced by a single valid/ready handshake, a synchronous flush, and an optional 2-deep skid buffer, so back-pressure never has a combinational path from downstream `out_ready` to upstream `in_ready`.

## Interface
- `WORD_WIDTH`, default 16: width of `npc`, `ir`, `sr1`, `sr2`.
- `CS_WIDTH`, default 20: control-store word width.
- `NZP_WIDTH`, default 3: width of `cc` and `drid`.
- `SKID`, default 1: 1 adds a skid entry with registered `in_ready`; 0 gives a single entry with combinational `in_ready`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  stage can accept a beat this cycle.
- `in_npc`, `in_ir`, `in_sr1`, `in_sr2`  in  WORD_WIDTH each  payload.
- `in_cs`  in  CS_WIDTH  control-store word.
- `in_cc`, `in_drid`  in  NZP_WIDTH each  condition codes and destination ID.
- `flush`  in  1  squash all held beats (branch mispredict / exception).
- `out_valid`  out  1  main entry holds a beat.
- `out_ready`  in  1  downstream accepts the beat this cycle.
- `out_npc`, `out_cs`, `out_ir`, `out_sr1`, `out_sr2`, `out_cc`, `out_drid`  out  field widths as on the input side  main-entry payload.
- `occupancy`  out  2  number of held beats: 0, 1 or 2.

## Operation
- Storage: main entry M (`m_valid`, payload) drives the `out_*` ports directly. Skid entry S (`s_valid`, payload) exists only when SKID=1.
- Handshakes: `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`; `out_valid = m_valid`.
- Payload is transferred as one atomic beat. No field loads independently.
- SKID=1, `in_ready = ~s_valid` (registered). States are EMPTY (M−,S−), ONE (M+,S−), FULL (M+,S+):
  - EMPTY: `in_fire` → M←in, go to ONE.
  - ONE, `out_fire` & `in_fire` → M←in, stay in ONE.
  - ONE, `out_fire` only → EMPTY.
  - ONE, `in_fire` only → S←in, go to FULL.
  - ONE, neither → hold.
  - FULL: `in_fire` is impossible. `out_fire` → M←S, clear S, go to ONE. Otherwise hold.
- SKID=0: `in_ready = ~m_valid | out_ready`. `in_fire` → M←in. `out_fire` without `in_fire` clears M. `occupancy` never exceeds 1.
- Ordering: beats leave in exactly the order accepted. S is never bypassed.
- `flush` (highest priority after `reset`): next state is EMPTY. Any beat accepted in the flush cycle is discarded. An `out_fire` in the flush cycle still counts as a transfer, because downstream sees `flush` too.
- `reset`: next state is EMPTY and all payload registers are cleared to 0.
- Payload registers hold their last value while the entry is invalid. The value is don't-care to downstream but must not toggle.
- `occupancy` = `m_valid + s_valid`, registered.

## Timing
- Reset values: `out_valid`=0, all `out_*` payload=0, `occupancy`=0, `in_ready`=1.
- Latency: a beat accepted at edge N appears on `out_*` with `out_valid`=1 after edge N, so it is visible in cycle N+1.
- Throughput: 1 beat/cycle in steady state with `out_ready`=1, in both modes.
- SKID=1, stall timing:
  - `out_ready` drops in cycle K while a beat is accepted → S fills at edge K.
  - `in_ready`=0 from cycle K+1.
  - `in_ready` returns to 1 the cycle after the first `out_fire` following the stall.
- SKID=1 has no combinational path from `out_ready` to `in_ready`.
- SKID=0 has a combinational path from `out_ready` to `in_ready`. No combinational path from `in_*` to `out_*` exists in either mode.
- Simultaneous `flush` and `reset`: the outcome is identical, i.e. reset values.

## Test plan
- Reset, then stream 8 beats (`in_npc` 0x3000, 0x3002, … 0x300E) with `out_ready`=1 → each appears exactly 1 cycle later, in order; `in_ready` stays 1; `occupancy` stays 1.
- SKID=1: hold `out_ready`=0 and offer 3 beats (A, B, C) → A in M, B in S, `in_ready`=0 and C stalls, `occupancy`=2. Raise `out_ready` → A, B, C delivered in order on consecutive cycles.
- `flush` asserted while FULL and `in_valid`=1 → next cycle `out_valid`=0, `occupancy`=0, `in_ready`=1. The beat offered in the flush cycle never appears on the output.
- SKID=0: `out_ready` toggles 1,0,1,0 under continuous input → `in_ready` mirrors `out_ready` whenever M is valid; no beat is lost or duplicated.
- Assert `reset` mid-stream while FULL with `cs`=0xFFFFF → next cycle all outputs are 0, `out_valid`=0, `in_ready`=1.
- CS_WIDTH=24, WORD_WIDTH=32: send a beat with all-ones payload → `out_cs`=0xFFFFFF and `out_sr1`=0xFFFFFFFF, with no truncation.
